// File: rtl/dll_pkg.sv
// Shared types for the doubly-linked-list queue engine and its command arbiter.
// Op encoding keeps the push/pop distinction in a single bit (OP_PUSH_B).
package dll_pkg;

    localparam int ID_N      = 4;
    localparam int W         = 32;
    localparam int ID_W      = (ID_N > 1) ? $clog2(ID_N) : 1;
    localparam int OP_PUSH_B = 1;

    typedef logic [W-1:0]    word_t;
    typedef logic [ID_W-1:0] id_t;
    typedef logic [ID_N-1:0] busy_t;
    typedef logic [ID_N-1:0] empty_t;

    typedef enum logic [1:0] {
        OP_POP_FRONT  = 2'b00,
        OP_POP_BACK   = 2'b01,
        OP_PUSH_FRONT = 2'b10,
        OP_PUSH_BACK  = 2'b11
    } op_t;

    typedef struct packed {
        logic  valid;
        op_t   op;
        word_t dat;
    } arb_req_t;

    function automatic logic is_push(input op_t op);
        logic [1:0] bits;
        bits = op;
        return bits[OP_PUSH_B];
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// rotating pointer; the pointer moves past the winner only when adv is strobed.
module rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

    // Wrap explicitly so non-power-of-two N never lands on an unused index.
    always_comb begin
        ptr_nxt = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv && found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/dll_arb.sv
// Command arbiter in front of the DLL queue engine: round-robin grant per slot,
// one outstanding command per queue ID, pop-on-empty rejection, push stall on full.
module dll_arb
    import dll_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_N-1:0]     req_vld,
    input  logic [2*ID_N-1:0]   req_op,
    input  logic [W*ID_N-1:0]   req_dat,
    output logic [ID_N-1:0]     req_ack,
    output logic [ID_N-1:0]     req_err,
    input  logic [ID_N-1:0]     q_empty,
    input  logic                q_full,
    output logic                cmd_vld,
    output logic [1:0]          cmd_op,
    output logic [ID_W-1:0]     cmd_id,
    output logic [W-1:0]        cmd_dat,
    input  logic                cmd_rdy,
    input  logic                rsp_vld,
    input  logic [ID_W-1:0]     rsp_id,
    output logic [ID_N-1:0]     busy
);

    // cmd handshake: a command transfers on any edge where cmd_vld && cmd_rdy;
    // while cmd_vld && !cmd_rdy every cmd_* output holds its value.

    arb_req_t reqs [ID_N];
    arb_req_t sel;
    id_t      sel_id;
    busy_t    eligible;
    busy_t    arb_in;
    busy_t    gnt;
    busy_t    busy_set;
    busy_t    busy_clr;
    logic     slot;
    logic     any_gnt;
    logic     rejected;
    logic     issue;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < ID_N; i++) begin
            reqs[i].valid = req_vld[i];
            reqs[i].op    = op_t'(req_op[2*i +: 2]);
            reqs[i].dat   = req_dat[W*i +: W];
            eligible[i]   = reqs[i].valid && !busy[i] &&
                            (!is_push(reqs[i].op) || !q_full);
        end
    end

    assign slot   = !cmd_vld || cmd_rdy;
    assign arb_in = slot ? eligible : '0;

    rr_arb #(.N(ID_N)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (arb_in),
        .adv (any_gnt && !rst),
        .gnt (gnt)
    );

    always_comb begin
        sel    = '0;
        sel_id = '0;
        for (int i = 0; i < ID_N; i++) begin
            if (gnt[i]) begin
                sel    = reqs[i];
                sel_id = id_t'(i);
            end
        end
    end

    assign any_gnt  = |gnt;
    // A rejected pop is acknowledged but leaves the cmd register and busy alone.
    assign rejected = any_gnt && sel.valid && !is_push(sel.op) && q_empty[sel_id];
    assign issue    = any_gnt && sel.valid && !rejected;

    assign req_ack = rst ? '0 : gnt;
    assign req_err = (rst || !rejected) ? '0 : gnt;

    always_comb begin
        busy_set = issue ? gnt : '0;
        busy_clr = '0;
        if (rsp_vld) begin
            busy_clr[rsp_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld <= 1'b0;
            cmd_op  <= '0;
            cmd_id  <= '0;
            cmd_dat <= '0;
        end else if (issue) begin
            cmd_vld <= 1'b1;
            cmd_op  <= sel.op;
            cmd_id  <= sel_id;
            cmd_dat <= is_push(sel.op) ? sel.dat : '0;
        end else if (cmd_rdy) begin
            cmd_vld <= 1'b0;
        end
    end

    rsp_without_busy: assert property (@(posedge clk) disable iff (rst)
        rsp_vld |-> busy[rsp_id]);

endmodule

// File: tb/tb_dll_arb.sv
// Directed bench for dll_arb: a vector table for reset, round-robin, rejection,
// backpressure and full stall, then hand sequences for serialization and reset.
module tb_dll_arb;

  logic         clk;
  logic         rst;
  logic [3:0]   req_vld;
  logic [7:0]   req_op;
  logic [127:0] req_dat;
  logic [3:0]   req_ack;
  logic [3:0]   req_err;
  logic [3:0]   q_empty;
  logic         q_full;
  logic         cmd_vld;
  logic [1:0]   cmd_op;
  logic [1:0]   cmd_id;
  logic [31:0]  cmd_dat;
  logic         cmd_rdy;
  logic         rsp_vld;
  logic [1:0]   rsp_id;
  logic [3:0]   busy;

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];

  dll_arb dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_op  (req_op),
    .req_dat (req_dat),
    .req_ack (req_ack),
    .req_err (req_err),
    .q_empty (q_empty),
    .q_full  (q_full),
    .cmd_vld (cmd_vld),
    .cmd_op  (cmd_op),
    .cmd_id  (cmd_id),
    .cmd_dat (cmd_dat),
    .cmd_rdy (cmd_rdy),
    .rsp_vld (rsp_vld),
    .rsp_id  (rsp_id),
    .busy    (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  vld;
    logic [7:0]  op;
    logic [31:0] base;
    logic [3:0]  empty;
    logic        full;
    logic        rdy;
    logic        rspv;
    logic [1:0]  rspid;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic        cvld;
    logic [1:0]  cid;
    logic [1:0]  cop;
    logic [31:0] cdat;
    logic [3:0]  bsy;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(
    input logic r, input logic [3:0] vld, input logic [7:0] op, input logic [31:0] base,
    input logic [3:0] empty, input logic full, input logic rdy, input logic rspv,
    input logic [1:0] rspid, input logic [3:0] ack, input logic [3:0] err, input logic cvld,
    input logic [1:0] cid, input logic [1:0] cop, input logic [31:0] cdat, input logic [3:0] bsy);
    vec_t v;
    v.r = r; v.vld = vld; v.op = op; v.base = base; v.empty = empty; v.full = full;
    v.rdy = rdy; v.rspv = rspv; v.rspid = rspid; v.ack = ack; v.err = err;
    v.cvld = cvld; v.cid = cid; v.cop = cop; v.cdat = cdat; v.bsy = bsy;
    return v;
  endfunction

  // driver: all inputs change on the falling edge; requester i pushes base+i
  task automatic drive(input logic r, input logic [3:0] vld, input logic [7:0] op,
                       input logic [31:0] base, input logic [3:0] empty, input logic full,
                       input logic rdy, input logic rspv, input logic [1:0] rspid);
    @(negedge clk);
    rst     = r;
    req_vld = vld;
    req_op  = op;
    for (int i = 0; i < 4; i++) req_dat[32*i +: 32] = base + 32'(i);
    q_empty = empty;
    q_full  = full;
    cmd_rdy = rdy;
    rsp_vld = rspv;
    rsp_id  = rspid;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // scoreboard: expected {cmd_id, cmd_dat} of each issued command, in order
  task automatic check_cmd(input string name);
    logic [33:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected command queued", name);
    end else begin
      e = exp_q.pop_front();
      if ({cmd_vld, cmd_id, cmd_dat} !== {1'b1, e}) begin
        bad++;
        $display("FAIL %s: got vld=%0b id=%0d dat=%0h want vld=1 id=%0d dat=%0h",
                 name, cmd_vld, cmd_id, cmd_dat, e[33:32], e[31:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; req_op = '0; req_dat = '0; q_empty = '0;
    q_full = 1'b0; cmd_rdy = 1'b0; rsp_vld = 1'b0; rsp_id = '0;

    // reset, then idle
    vecs[0]  = mk(1'b1, 4'h0, 8'h00, 32'h0,    4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 32'h0,    4'h0);
    vecs[1]  = mk(1'b1, 4'h0, 8'h00, 32'h0,    4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 32'h0,    4'h0);
    vecs[2]  = mk(1'b0, 4'h0, 8'h00, 32'h0,    4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 32'h0,    4'h0);
    vecs[3]  = mk(1'b0, 4'h0, 8'h00, 32'h0,    4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 32'h0,    4'h0);
    // round-robin pushes, responses one cycle after each acceptance
    vecs[4]  = mk(1'b0, 4'hF, 8'hFF, 32'h0,    4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h1, 4'h0, 1'b1, 2'd0, 2'd3, 32'h0,    4'h1);
    vecs[5]  = mk(1'b0, 4'hF, 8'hFF, 32'h0,    4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h2, 4'h0, 1'b1, 2'd1, 2'd3, 32'h1,    4'h3);
    vecs[6]  = mk(1'b0, 4'hF, 8'hFF, 32'h0,    4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 4'h4, 4'h0, 1'b1, 2'd2, 2'd3, 32'h2,    4'h6);
    vecs[7]  = mk(1'b0, 4'hF, 8'hFF, 32'h0,    4'h0, 1'b0, 1'b1, 1'b1, 2'd1, 4'h8, 4'h0, 1'b1, 2'd3, 2'd3, 32'h3,    4'hC);
    vecs[8]  = mk(1'b0, 4'h0, 8'hFF, 32'h0,    4'h0, 1'b0, 1'b1, 1'b1, 2'd2, 4'h0, 4'h0, 1'b0, 2'd3, 2'd3, 32'h3,    4'h8);
    vecs[9]  = mk(1'b0, 4'h0, 8'hFF, 32'h0,    4'h0, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 1'b0, 2'd3, 2'd3, 32'h3,    4'h0);
    // pop on empty queue 2, then pointer shown to sit at 3
    vecs[10] = mk(1'b0, 4'h4, 8'h00, 32'h0,    4'h4, 1'b0, 1'b1, 1'b0, 2'd0, 4'h4, 4'h4, 1'b0, 2'd3, 2'd3, 32'h3,    4'h0);
    vecs[11] = mk(1'b0, 4'h9, 8'hFF, 32'h10,   4'h4, 1'b0, 1'b1, 1'b0, 2'd0, 4'h8, 4'h0, 1'b1, 2'd3, 2'd3, 32'h13,   4'h8);
    vecs[12] = mk(1'b0, 4'h0, 8'hFF, 32'h10,   4'h4, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd3, 2'd3, 32'h13,   4'h8);
    vecs[13] = mk(1'b0, 4'h0, 8'hFF, 32'h10,   4'h0, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 1'b0, 2'd3, 2'd3, 32'h13,   4'h0);
    // backpressure: id 1 PUSH_FRONT DEAD held 5 cycles, requester 2 waiting
    vecs[14] = mk(1'b0, 4'h6, 8'h38, 32'hDEAC, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h2, 4'h0, 1'b1, 2'd1, 2'd2, 32'hDEAD, 4'h2);
    for (int i = 15; i < 20; i++)
      vecs[i] = mk(1'b0, 4'h6, 8'h38, 32'hDEAC, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 2'd1, 2'd2, 32'hDEAD, 4'h2);
    vecs[20] = mk(1'b0, 4'h6, 8'h38, 32'hDEAC, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h4, 4'h0, 1'b1, 2'd2, 2'd3, 32'hDEAE, 4'h6);
    vecs[21] = mk(1'b0, 4'h0, 8'h38, 32'hDEAC, 4'h0, 1'b0, 1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 1'b0, 2'd2, 2'd3, 32'hDEAE, 4'h4);
    vecs[22] = mk(1'b0, 4'h0, 8'h38, 32'hDEAC, 4'h0, 1'b0, 1'b1, 1'b1, 2'd2, 4'h0, 4'h0, 1'b0, 2'd2, 2'd3, 32'hDEAE, 4'h0);
    // full stall: push from 3 waits, pop from 1 proceeds
    vecs[23] = mk(1'b0, 4'hA, 8'hC4, 32'h100,  4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h2, 4'h0, 1'b1, 2'd1, 2'd1, 32'h0,    4'h2);
    vecs[24] = mk(1'b0, 4'h8, 8'hC4, 32'h100,  4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd1, 2'd1, 32'h0,    4'h2);
    vecs[25] = mk(1'b0, 4'h8, 8'hC4, 32'h100,  4'h0, 1'b0, 1'b1, 1'b1, 2'd1, 4'h8, 4'h0, 1'b1, 2'd3, 2'd3, 32'h103,  4'h8);
    vecs[26] = mk(1'b0, 4'h0, 8'hC4, 32'h100,  4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd3, 2'd3, 32'h103,  4'h8);
    vecs[27] = mk(1'b0, 4'h0, 8'hC4, 32'h100,  4'h0, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 1'b0, 2'd3, 2'd3, 32'h103,  4'h0);

    for (int n = 0; n < 28; n++) begin
      drive(vecs[n].r, vecs[n].vld, vecs[n].op, vecs[n].base, vecs[n].empty,
            vecs[n].full, vecs[n].rdy, vecs[n].rspv, vecs[n].rspid);
      #1;
      check($sformatf("v%0d_ack", n), 64'(req_ack), 64'(vecs[n].ack));
      check($sformatf("v%0d_err", n), 64'(req_err), 64'(vecs[n].err));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cmd_vld", n), 64'(cmd_vld), 64'(vecs[n].cvld));
      check($sformatf("v%0d_cmd_id", n),  64'(cmd_id),  64'(vecs[n].cid));
      check($sformatf("v%0d_cmd_op", n),  64'(cmd_op),  64'(vecs[n].cop));
      check($sformatf("v%0d_cmd_dat", n), 64'(cmd_dat), 64'(vecs[n].cdat));
      check($sformatf("v%0d_busy", n),    64'(busy),    64'(vecs[n].bsy));
    end

    // per-ID serialization: 0 and 1 granted, 0 then held busy for 10 cycles
    drive(1'b0, 4'b0011, 8'hFF, 32'h500, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1 check("t5_ack0", 64'(req_ack), 64'(4'b0001));
    exp_q.push_back({2'd0, 32'h500});
    @(posedge clk); #1 check_cmd("t5_cmd0");
    check("t5_busy0", 64'(busy), 64'(4'b0001));
    drive(1'b0, 4'b0011, 8'hFF, 32'h500, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1 check("t5_ack1", 64'(req_ack), 64'(4'b0010));
    exp_q.push_back({2'd1, 32'h501});
    @(posedge clk); #1 check_cmd("t5_cmd1");
    check("t5_busy01", 64'(busy), 64'(4'b0011));
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 4'b0001, 8'hFF, 32'h500, 4'h0, 1'b0, 1'b1, (k == 0), 2'd1);
      #1 check($sformatf("t5_hold_ack%0d", k), 64'(req_ack), 64'(4'b0000));
      @(posedge clk); #1;
      check($sformatf("t5_hold_busy%0d", k), 64'(busy), 64'(4'b0001));
      check($sformatf("t5_hold_vld%0d", k), 64'(cmd_vld), 64'(1'b0));
    end
    drive(1'b0, 4'b0001, 8'hFF, 32'h500, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0);
    #1 check("t5_rsp_ack", 64'(req_ack), 64'(4'b0000));
    @(posedge clk); #1 check("t5_rsp_busy", 64'(busy), 64'(4'b0000));
    drive(1'b0, 4'b0001, 8'hFF, 32'h500, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1 check("t5_regrant_ack", 64'(req_ack), 64'(4'b0001));
    exp_q.push_back({2'd0, 32'h500});
    @(posedge clk); #1 check_cmd("t5_regrant_cmd");
    check("t5_regrant_busy", 64'(busy), 64'(4'b0001));

    // reset mid-operation: in-flight state and pointer discarded
    drive(1'b1, 4'b1111, 8'hFF, 32'h600, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    #1 check("rst_ack", 64'(req_ack), 64'(4'b0000));
    check("rst_err", 64'(req_err), 64'(4'b0000));
    @(posedge clk); #1;
    check("rst_vld", 64'(cmd_vld), 64'(1'b0));
    check("rst_busy", 64'(busy), 64'(4'b0000));
    drive(1'b0, 4'b1111, 8'hFF, 32'h600, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1 check("post_rst_ack", 64'(req_ack), 64'(4'b0001));
    exp_q.push_back({2'd0, 32'h600});
    @(posedge clk); #1 check_cmd("post_rst_cmd");
    check("post_rst_busy", 64'(busy), 64'(4'b0001));
    drive(1'b0, 4'b0000, 8'hFF, 32'h600, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    @(posedge clk); #1 check("drain_vld", 64'(cmd_vld), 64'(1'b0));
    drive(1'b0, 4'b0000, 8'hFF, 32'h600, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0);
    @(posedge clk); #1 check("drain_busy", 64'(busy), 64'(4'b0000));
    drive(1'b0, 4'b0000, 8'hFF, 32'h600, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    check("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
